alu_exec_sequencer: RTL and testbench

- Multi-cycle execute/writeback controller that sits directly in front of the 16-bit register file.
- Accepts one decoded ALU instruction, drives the register file read addresses, latches both operands, and computes the result and flags.
- Writes the result back through the register file's write port, which writes the register addressed by ra2.
- Handshake is start/busy/done toward the instruction decoder.

---
 rtl/alu_exec_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_sequencer.sv
// Execute/writeback sequencer in front of a 16-bit register file: IDLE -> FETCH -> EXEC -> WB.
// Optional macro ALU_MUL_EN makes op 9 an unsigned multiply with a two-cycle EXEC.
module alu_exec_sequencer #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [REGBITS-1:0] rsrc,
  input  logic [REGBITS-1:0] rdest,
  input  logic [7:0]         imm,
  input  logic               use_imm,
  input  logic [WIDTH-1:0]   rd1,
  input  logic [WIDTH-1:0]   rd2,
  output logic [REGBITS-1:0] ra1,
  output logic [REGBITS-1:0] ra2,
  output logic               regwrite,
  output logic [WIDTH-1:0]   wd,
  output logic               busy,
  output logic               done,
  output logic [4:0]         flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_RSH = 4'd8;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
`endif

  localparam int FL_C = 4;
  localparam int FL_L = 3;
  localparam int FL_F = 2;
  localparam int FL_Z = 1;
  localparam int FL_N = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_op;
  logic [REGBITS-1:0]   r_rdest;
  logic [7:0]           r_imm;
  logic                 r_use_imm;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     w_result;
  logic [4:0]           w_flags;
  logic                 w_writes;
  logic                 w_exec_last;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;

`ifdef ALU_MUL_EN
  logic                 r_mul_cnt;
  assign w_exec_last = (r_op != OP_MUL) || r_mul_cnt;
`else
  assign w_exec_last = 1'b1;
`endif

  // The extra top bit of the subtraction is the unsigned borrow.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
        else       w_next_state = S_IDLE;
      end
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_exec_last) w_next_state = S_WB;
        else             w_next_state = S_EXEC;
      end
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_result = wd;
    w_flags  = flags;
    w_writes = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_result       = w_sum[WIDTH-1:0];
        w_flags[FL_C]  = w_sum[WIDTH];
        w_flags[FL_F]  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        w_writes       = 1'b1;
      end
      OP_SUB: begin
        w_result       = w_diff[WIDTH-1:0];
        w_flags[FL_C]  = w_diff[WIDTH];
        w_flags[FL_F]  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
        w_writes       = 1'b1;
      end
      OP_AND: begin w_result = r_a & r_b; w_writes = 1'b1; end
      OP_OR:  begin w_result = r_a | r_b; w_writes = 1'b1; end
      OP_XOR: begin w_result = r_a ^ r_b; w_writes = 1'b1; end
      OP_CMP: begin
        w_flags[FL_L] = r_a < r_b;
        w_flags[FL_N] = $signed(r_a) < $signed(r_b);
        w_flags[FL_Z] = r_a == r_b;
      end
      OP_MOV: begin w_result = r_b; w_writes = 1'b1; end
      OP_LSH: begin w_result = r_a << r_b[3:0]; w_writes = 1'b1; end
      OP_RSH: begin w_result = r_a >> r_b[3:0]; w_writes = 1'b1; end
`ifdef ALU_MUL_EN
      OP_MUL: begin w_result = r_a * r_b; w_writes = 1'b1; end
`endif
      default: begin
        w_result = wd;
        w_writes = 1'b0;
      end
    endcase
  end

  // Address, operand and result registers; every output is driven straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= 4'd0;
      r_rdest   <= {REGBITS{1'b0}};
      r_imm     <= 8'd0;
      r_use_imm <= 1'b0;
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      ra1       <= {REGBITS{1'b0}};
      ra2       <= {REGBITS{1'b0}};
      wd        <= {WIDTH{1'b0}};
      flags     <= 5'd0;
      regwrite  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ALU_MUL_EN
      r_mul_cnt <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_rdest   <= rdest;
            r_imm     <= imm;
            r_use_imm <= use_imm;
            ra1       <= rsrc;
            ra2       <= rdest;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          r_a <= rd2;
          r_b <= r_use_imm ? {{(WIDTH-8){r_imm[7]}}, r_imm} : rd1;
        end
        S_EXEC: begin
`ifdef ALU_MUL_EN
          r_mul_cnt <= (r_op == OP_MUL) && !r_mul_cnt;
`endif
          if (w_exec_last) begin
            wd       <= w_result;
            flags    <= w_flags;
            regwrite <= w_writes && (r_rdest != {REGBITS{1'b0}});
            done     <= 1'b1;
          end
        end
        S_WB: begin
          regwrite <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          regwrite <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: register-file environment, transaction-level model, per-cycle compare.
module tb_alu_exec_sequencer;

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, use_imm;
  logic [3:0]  op, rsrc, rdest;
  logic [7:0]  imm;
  logic [15:0] rd1, rd2, wd;
  logic [3:0]  ra1, ra2;
  logic        regwrite, busy, done;
  logic [4:0]  flags;

  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] env_regs [16];

  int n_cmp  = 0;
  int n_fail = 0;

  string       req_name;
  logic [31:0] req_act, req_exp;
  int          req_seq = 0;

  int          cap_lat;
  logic [15:0] cap_wd;
  logic        cap_we;
  logic [4:0]  cap_fl;

  logic [15:0] m_regs [16];
  int          m_cnt, m_lat;
  logic [3:0]  m_rdest, m_ra1, m_ra2;
  logic [15:0] m_res, last_m_res;
  logic        m_we, m_wr;
  logic [4:0]  m_flags, m_nflags;

  always #5 clk = ~clk;

  alu_exec_sequencer #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rsrc(rsrc), .rdest(rdest),
    .imm(imm), .use_imm(use_imm), .rd1(rd1), .rd2(rd2), .ra1(ra1), .ra2(ra2),
    .regwrite(regwrite), .wd(wd), .busy(busy), .done(done), .flags(flags)
  );

  // Register file environment: combinational reads, r0 reads as zero.
  assign rd1 = (ra1 == 4'd0) ? 16'h0000 : env_regs[ra1];
  assign rd2 = (ra2 == 4'd0) ? 16'h0000 : env_regs[ra2];

  always @(posedge clk) begin
    if (pl_en) env_regs[pl_addr] <= pl_data;
    else if (regwrite && ra2 != 4'd0) env_regs[ra2] <= wd;
  end

  function automatic logic [15:0] mreg(input logic [3:0] a);
    return (a == 4'd0) ? 16'h0000 : m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model + compare: checks the current cycle, then advances by one clock.
  initial begin
    logic [15:0] a, b;
    longint ua, ub, sa, sb, t;
    bit in_wb;
    int seen;
    seen = 0; m_cnt = 0; m_lat = 3; m_flags = 5'd0; m_nflags = 5'd0;
    m_ra1 = 4'd0; m_ra2 = 4'd0; m_rdest = 4'd0; m_res = 16'h0; last_m_res = 16'h0;
    m_we = 1'b0; m_wr = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_cnt = 0; m_flags = 5'd0; m_ra1 = 4'd0; m_ra2 = 4'd0;
      end
      in_wb = (m_cnt != 0) && (m_cnt == m_lat);
      chk("busy", busy, m_cnt != 0);
      chk("done", done, in_wb);
      chk("regwrite", regwrite, in_wb && m_we);
      chk("flags", flags, m_flags);
      chk("ra1", ra1, m_ra1);
      chk("ra2", ra2, m_ra2);
      if (reset) chk("wd_reset", wd, 32'h0);
      if (in_wb && m_wr) begin
        chk("wd", wd, m_res);
        last_m_res = m_res;
      end
      if (req_seq != seen) begin
        seen = req_seq;
        chk(req_name, req_act, req_exp);
      end
      if (pl_en) m_regs[pl_addr] = pl_data;
      if (!reset) begin
        if (m_cnt == 0) begin
          if (start) begin
            a = mreg(rdest);
            b = use_imm ? {{8{imm[7]}}, imm} : mreg(rsrc);
            ua = longint'(a); ub = longint'(b);
            sa = longint'($signed(a)); sb = longint'($signed(b));
            m_nflags = m_flags; m_wr = 1'b1; m_res = 16'h0;
            case (op)
              4'd0: begin t = ua + ub; m_res = 16'(t); m_nflags[4] = t > 65535;
                          m_nflags[2] = (sa + sb > 32767) || (sa + sb < -32768); end
              4'd1: begin t = ua - ub; m_res = 16'(t); m_nflags[4] = ua < ub;
                          m_nflags[2] = (sa - sb > 32767) || (sa - sb < -32768); end
              4'd2: m_res = a & b;
              4'd3: m_res = a | b;
              4'd4: m_res = a ^ b;
              4'd5: begin m_wr = 1'b0; m_nflags[3] = ua < ub; m_nflags[0] = sa < sb;
                          m_nflags[1] = ua == ub; end
              4'd6: m_res = b;
              4'd7: m_res = 16'(ua << (ub % 16));
              4'd8: m_res = 16'(ua >> (ub % 16));
              4'd9: if (MUL_ON) m_res = 16'(ua * ub); else m_wr = 1'b0;
              default: m_wr = 1'b0;
            endcase
            m_rdest = rdest;
            m_we    = m_wr && (rdest != 4'd0);
            m_lat   = (MUL_ON && op == 4'd9) ? 4 : 3;
            m_ra1   = rsrc;
            m_ra2   = rdest;
            m_cnt   = 1;
          end
        end else if (in_wb) begin
          if (m_we) m_regs[m_rdest] = m_res;
          m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == m_lat) m_flags = m_nflags;
        end
      end
    end
  end

  // Hands one literal expectation to the compare process and waits for it to be taken.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    #1;
    req_name = name; req_act = act; req_exp = exp; req_seq++;
    @(negedge clk); #1;
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                     input logic [7:0] im, input logic ui);
    @(posedge clk); #1;
    op = o; rdest = d; rsrc = s; imm = im; use_imm = ui; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cap_lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        cap_lat = i + 1; cap_wd = wd; cap_we = regwrite; cap_fl = flags;
        break;
      end
    end
    lit("latency", cap_lat, (MUL_ON && o == 4'd9) ? 32'd4 : 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nd, first, second;
    reset = 1'b1; start = 1'b0; op = 4'd0; rsrc = 4'd0; rdest = 4'd0;
    imm = 8'd0; use_imm = 1'b0; pl_en = 1'b0; pl_addr = 4'd0; pl_data = 16'h0;
    repeat (2) @(posedge clk); #1;
    pl_en = 1'b1;
    for (int i = 1; i < 16; i++) begin
      pl_addr = 4'(i); pl_data = 16'(i * 16'h0111);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    lit("rst_wd", wd, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    set_reg(4'd3, 16'h0005); set_reg(4'd4, 16'h0003);
    run(4'd0, 4'd3, 4'd4, 8'h00, 1'b0);
    lit("add_wd", cap_wd, 32'h0008);
    lit("add_we", cap_we, 32'h1);
    lit("add_CF", {cap_fl[4], cap_fl[2]}, 32'h0);
    lit("model_add", last_m_res, 32'h0008);

    set_reg(4'd3, 16'h7FFF); set_reg(4'd4, 16'h0001);
    run(4'd0, 4'd3, 4'd4, 8'h00, 1'b0);
    lit("ovf_wd", cap_wd, 32'h8000);
    lit("ovf_CF", {cap_fl[4], cap_fl[2]}, 32'h1);
    set_reg(4'd3, 16'h0000);
    run(4'd1, 4'd3, 4'd4, 8'h00, 1'b0);
    lit("sub_wd", cap_wd, 32'hFFFF);
    lit("sub_CF", {cap_fl[4], cap_fl[2]}, 32'h2);

    set_reg(4'd3, 16'h0002); set_reg(4'd4, 16'hFFFF);
    run(4'd5, 4'd3, 4'd4, 8'h00, 1'b0);
    lit("cmp_flags", cap_fl, 32'h18);
    lit("cmp_we", cap_we, 32'h0);

    set_reg(4'd5, 16'h0010);
    run(4'd0, 4'd5, 4'd0, 8'hFF, 1'b1);
    lit("imm_wd", cap_wd, 32'h000F);
    lit("imm_C", cap_fl[4], 32'h1);
    run(4'd0, 4'd0, 4'd0, 8'hFF, 1'b1);
    lit("r0_we", cap_we, 32'h0);
    lit("model_r0", last_m_res, 32'hFFFF);

    set_reg(4'd7, 16'h0001);
    run(4'd7, 4'd7, 4'd0, 8'h04, 1'b1);
    lit("lsh_wd", cap_wd, 32'h0010);
    set_reg(4'd7, 16'h8000);
    run(4'd8, 4'd7, 4'd0, 8'h13, 1'b1);
    lit("rsh_wd", cap_wd, 32'h1000);
    run(4'd6, 4'd14, 4'd0, 8'h80, 1'b1);
    lit("mov_wd", cap_wd, 32'hFF80);
    run(4'd0, 4'd6, 4'd6, 8'h00, 1'b0);
    lit("same_reg_wd", cap_wd, 32'h0CCC);
    set_reg(4'd3, 16'h8000); set_reg(4'd4, 16'h0001);
    run(4'd1, 4'd3, 4'd4, 8'h00, 1'b0);
    lit("sub_ovf_F", cap_fl[2], 32'h1);
    run(4'd2, 4'd8, 4'd9, 8'h00, 1'b0);
    run(4'd3, 4'd10, 4'd11, 8'h00, 1'b0);
    run(4'd4, 4'd12, 4'd13, 8'h00, 1'b0);
    run(4'd9, 4'd2, 4'd10, 8'h00, 1'b0);
    run(4'd12, 4'd2, 4'd10, 8'h00, 1'b0);
    lit("nop_we", cap_we, 32'h0);

    @(posedge clk); #1;
    op = 4'd0; rdest = 4'd1; rsrc = 4'd0; imm = 8'h01; use_imm = 1'b1; start = 1'b1;
    nd = 0; first = -1; second = -1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c == 7) start = 1'b0;
      @(negedge clk);
      if (done) begin
        if (nd == 0) first = c; else second = c;
        nd++;
      end
    end
    lit("hs_count", nd, 32'd2);
    lit("hs_gap", second - first, 32'd4);

    set_reg(4'd3, 16'h1234); set_reg(4'd4, 16'h0001);
    @(posedge clk); #1;
    op = 4'd0; rdest = 4'd3; rsrc = 4'd4; use_imm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    lit("rst_busy", busy, 32'h0);
    lit("rst_regwrite", regwrite, 32'h0);
    lit("rst_flags", flags, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    lit("r3_kept", env_regs[3], 32'h1234);
    run(4'd0, 4'd3, 4'd4, 8'h00, 1'b0);
    lit("post_rst_wd", cap_wd, 32'h1235);
    @(posedge clk); #1;
    lit("r3_new", env_regs[3], 32'h1235);

    for (int i = 1; i < 16; i++) lit($sformatf("reg%0d", i), env_regs[i], m_regs[i]);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
